ripple_sub_serial: RTL and testbench

//  Bit-serial inverse of the 5-bit gate-level ripple adder: recovers operand a from
//  the adder result ({cout,y}), operand b and carry-in, one bit per clock.

---
 rtl/ripple_sub_serial_if.sv | 25 ++
 rtl/ripple_sub_serial.sv | 110 +++++++++++
 tb/tb_ripple_sub_serial.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ripple_sub_serial_if.sv
// Request/response bundle for the bit-serial ripple subtractor.
interface ripple_sub_serial_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic             err;

  modport master (
    output in_valid, y, cout, b, cin, out_ready,
    input  in_ready, out_valid, a, err
  );

  modport slave (
    input  in_valid, y, cout, b, cin, out_ready,
    output in_ready, out_valid, a, err
  );
endinterface

// File: rtl/ripple_sub_serial.sv
// Bit-serial inverse of the ripple adder: a = {cout,y} - b - cin, index WIDTH-1 is LSB.
// Define RIPPLE_SUB_BACK2BACK_EN to accept a new request in the DONE handoff cycle.
module ripple_sub_serial #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_sub_serial_if.slave   bus,
  output logic                 busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             cout_q, cout_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx;
  logic             yi, bi, bo;
  logic             in_ready;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      b_q      <= '0;
      a_q      <= '0;
      cout_q   <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      b_q      <= b_d;
      a_q      <= a_d;
      cout_q   <= cout_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    idx      = LAST - cnt_q;
    yi       = y_q[idx];
    bi       = b_q[idx];
    bo       = (~yi & bi) | (~(yi ^ bi) & borrow_q);
`ifdef RIPPLE_SUB_BACK2BACK_EN
    in_ready = (state_q == IDLE) ||
               ((state_q == DONE) && bus.out_ready);
`else
    in_ready = (state_q == IDLE);
`endif
    accept   = bus.in_valid && in_ready;

    state_d  = state_q;
    y_d      = y_q;
    b_d      = b_q;
    a_d      = a_q;
    cout_d   = cout_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      RUN: begin
        a_d[idx] = yi ^ bi ^ borrow_q;
        borrow_d = bo;
        if (cnt_q == LAST) begin
          state_d = DONE;
          err_d   = cout_q ^ bo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // accept can only fire in DONE when back-to-back handoff is built in
    if (accept) begin
      state_d  = RUN;
      y_d      = bus.y;
      b_d      = bus.b;
      cout_d   = bus.cout;
      borrow_d = bus.cin;
      cnt_d    = '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.a         = a_q;
  assign bus.err       = err_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ripple_sub_serial.sv
// Directed + random scoreboard bench for ripple_sub_serial (WIDTH=5).
// Values are given in arithmetic weight and bit-reversed onto the pins.
module tb_ripple_sub_serial;
  localparam int W = 5;

  typedef struct {
    logic [W-1:0] a;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  ripple_sub_serial_if #(.WIDTH(W)) bus ();

  ripple_sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int y, input int co,
                                 input int b, input int ci);
    exp_t e;
    int   t;
    t     = co * 32 + y - b - ci;
    e.err = (t < 0) || (t > 31);
    e.a   = W'(t & 31);
    return e;
  endfunction

  task automatic send(input int y, input int co, input int b, input int ci,
                      input int ea, input int ee);
    int   t = 0;
    exp_t e;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", 32'(t < 50), 32'd1);
    bus.in_valid = 1'b1;
    bus.y        = rev(W'(y));
    bus.cout     = co[0];
    bus.b        = rev(W'(b));
    bus.cin      = ci[0];
    @(posedge clk);
    e.a   = W'(ea);
    e.err = ee[0];
    exp_q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
    bus.y        = W'($urandom);
    bus.b        = W'($urandom);
    bus.cout     = 1'($urandom);
    bus.cin      = 1'($urandom);
  endtask

  task automatic wait_out(input string tag, input logic chk_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat) check({tag, "_lat"}, lat, W + 1);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check({tag, "_qnz"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_a"}, 32'(rev(bus.a)), 32'(e.a));
      check({tag, "_err"}, 32'(bus.err), 32'(e.err));
    end
  endtask

  task automatic recv(input string tag, input logic chk_lat);
    wait_out(tag, chk_lat);
    pop_cmp(tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ha;
    logic         he;
    exp_t         m;
    int           ry, rc, rb, ri;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y         = '0;
    bus.b         = '0;
    bus.cout      = 1'b0;
    bus.cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", 32'(bus.a), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    send(8, 0, 3, 0, 5, 0);
    recv("c1", 1'b1);
    send(4, 1, 30, 1, 5, 0);
    recv("c2", 1'b1);
    send(2, 0, 3, 0, 31, 1);
    recv("c3", 1'b1);
    send(31, 1, 0, 0, 31, 1);
    recv("c4a", 1'b1);
    send(31, 0, 0, 0, 31, 0);
    recv("c4b", 1'b1);

    // hold result with out_ready low while in_valid toggles
    send(8, 0, 3, 0, 5, 0);
    wait_out("c5", 1'b1);
    pop_cmp("c5");
    ha = bus.a;
    he = bus.err;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.y        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      check("hold_a", 32'(bus.a), 32'(ha));
      check("hold_err", 32'(bus.err), 32'(he));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // reset in the third RUN cycle
    send(8, 0, 3, 0, 5, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_a", 32'(bus.a), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    send(8, 0, 3, 0, 5, 0);
    recv("c6", 1'b1);

    for (int k = 0; k < 8; k++) begin
      ry = int'($urandom_range(0, 31));
      rc = int'($urandom_range(0, 1));
      rb = int'($urandom_range(0, 31));
      ri = int'($urandom_range(0, 1));
      m  = model(ry, rc, rb, ri);
      send(ry, rc, rb, ri, int'(m.a), int'(m.err));
      recv("rnd", 1'b1);
    end

`ifdef RIPPLE_SUB_BACK2BACK_EN
    begin
      int gap = 0;
      send(8, 0, 3, 0, 5, 0);
      wait_out("b2b1", 1'b1);
      pop_cmp("b2b1");
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.y         = rev(W'(2));
      bus.cout      = 1'b0;
      bus.b         = rev(W'(3));
      bus.cin       = 1'b0;
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      m.a   = W'(31);
      m.err = 1'b1;
      exp_q.push_back(m);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      do begin
        @(negedge clk);
        gap++;
      end while (!bus.out_valid && gap < 50);
      check("b2b_gap", gap, W + 1);
      pop_cmp("b2b2");
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
